cp0_cause_irq: RTL and testbench

//  Parametrised CP0 CAUSE register (Reg 13) with a built-in interrupt front end.

---
 rtl/cp0_cause_irq.sv | 128 ++++++++++++
 tb/tb_cp0_cause_irq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_cause_irq.sv
// CP0 CAUSE register (Reg 13) with an interrupt front end: per-line synchroniser,
// level or sticky rising-edge pending, software IP bits, exception fields and a registered irq_req.
module cp0_cause_irq #(
  parameter int         N_EXT       = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] EDGE_MASK   = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_EXT-1:0] irq_in,
  input  logic [N_EXT-1:0] irq_clr,
  input  logic             timer_pending,
  input  logic             activeexception,
  input  logic [4:0]       exccode,
  input  logic             exc_in_delay_slot,
  input  logic             mtc0_we,
  input  logic [31:0]      mtc0_wdata,
  input  logic [7:0]       status_im,
  input  logic             status_ie,
  input  logic             status_exl,
  output logic [31:0]      cause,
  output logic             irq_req
);

  logic [N_EXT-1:0] sync_s;
  logic [N_EXT-1:0] prev_q;
  logic [N_EXT-1:0] pend_q, pend_d;
  logic [N_EXT-1:0] ip_ext_q;
  logic [3:0]       ip_ext_s;
  logic             ti_q;
  logic [1:0]       sw_q, sw_d;
  logic [4:0]       exc_q, exc_d;
  logic             bd_q, bd_d;
  logic             irq_q, irq_d;
  logic             unused_wdata_s;

  assign unused_wdata_s = ^{mtc0_wdata[31:10], mtc0_wdata[7:0]};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_s = irq_in;
    end else begin : g_sync
      logic [N_EXT-1:0] chain_q [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < SYNC_STAGES; j++) chain_q[j] <= {N_EXT{1'b0}};
        end else begin
          chain_q[0] <= irq_in;
          for (int j = 1; j < SYNC_STAGES; j++) chain_q[j] <= chain_q[j-1];
        end
      end

      assign sync_s = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edge lines: a new rising edge beats a same-cycle clear.
  always_comb begin
    pend_d = {N_EXT{1'b0}};
    for (int i = 0; i < N_EXT; i++) begin
      if (EDGE_MASK[i]) begin
        pend_d[i] = (sync_s[i] & ~prev_q[i]) | (pend_q[i] & ~irq_clr[i]);
      end else begin
        pend_d[i] = sync_s[i];
      end
    end
  end

  always_comb begin
    sw_d  = sw_q;
    exc_d = exc_q;
    bd_d  = bd_q;
    if (mtc0_we) begin
      sw_d = mtc0_wdata[9:8];
    end else begin
      sw_d = sw_q;
    end
    if (activeexception) begin
      exc_d = exccode;
      bd_d  = exc_in_delay_slot;
    end else begin
      exc_d = exc_q;
      bd_d  = bd_q;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_ipext
      if (g < N_EXT) begin : g_present
        assign ip_ext_s[g] = ip_ext_q[g];
      end else begin : g_absent
        assign ip_ext_s[g] = 1'b0;
      end
    end
  endgenerate

  assign cause = {bd_q, ti_q, 14'b0, ip_ext_s, ti_q, 1'b0, sw_q, 1'b0, exc_q, 2'b00};

  // Request is taken from the registered cause, so it trails cause by one cycle.
  assign irq_d = (|(cause[15:8] & status_im)) & status_ie & ~status_exl;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= {N_EXT{1'b0}};
      pend_q   <= {N_EXT{1'b0}};
      ip_ext_q <= {N_EXT{1'b0}};
      ti_q     <= 1'b0;
      sw_q     <= 2'b00;
      exc_q    <= 5'd0;
      bd_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      prev_q   <= sync_s;
      pend_q   <= pend_d;
      ip_ext_q <= pend_q;
      ti_q     <= timer_pending;
      sw_q     <= sw_d;
      exc_q    <= exc_d;
      bd_q     <= bd_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_req = irq_q;

endmodule

// File: tb/tb_cp0_cause_irq.sv
// Bench for cp0_cause_irq: directed steps then random traffic, every cycle compared
// against an index-based reference model of the CAUSE fields and irq_req.
module tb_cp0_cause_irq;
  localparam int         S    = 2;
  localparam logic [3:0] EDGE = 4'b0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_in = 4'hF;
  logic [3:0]  irq_clr = 4'h0;
  logic        timer_pending = 1'b1;
  logic        activeexception = 1'b0;
  logic [4:0]  exccode = 5'd0;
  logic        exc_in_delay_slot = 1'b0;
  logic        mtc0_we = 1'b0;
  logic [31:0] mtc0_wdata = 32'h0;
  logic [7:0]  status_im = 8'h00;
  logic        status_ie = 1'b0;
  logic        status_exl = 1'b0;
  logic [31:0] cause;
  logic        irq_req;

  cp0_cause_irq #(.N_EXT(4), .SYNC_STAGES(S), .EDGE_MASK(EDGE)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .irq_clr(irq_clr),
    .timer_pending(timer_pending), .activeexception(activeexception),
    .exccode(exccode), .exc_in_delay_slot(exc_in_delay_slot),
    .mtc0_we(mtc0_we), .mtc0_wdata(mtc0_wdata), .status_im(status_im),
    .status_ie(status_ie), .status_exl(status_exl), .cause(cause), .irq_req(irq_req)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rst = -1;
  logic [3:0] in_hist [0:8191];

  // Model state: what cause/irq_req should hold after the latest edge.
  logic [3:0] m_ext = 4'h0, m_sticky = 4'h0;
  logic       m_ti = 1'b0, m_bd = 1'b0, m_irq = 1'b0;
  logic [1:0] m_sw = 2'b00;
  logic [4:0] m_exc = 5'd0;

  function automatic logic [3:0] in_at(int m);
    return (m > last_rst) ? in_hist[m] : 4'h0;
  endfunction

  function automatic logic [31:0] exp_cause();
    return {m_bd, m_ti, 14'b0, m_ext, m_ti, 1'b0, m_sw, 1'b0, m_exc, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [3:0] rise, lvl, nxt_ext, nxt_sticky;
    in_hist[cyc] = irq_in;
    if (reset) begin
      last_rst = cyc;
      m_ext = 4'h0; m_sticky = 4'h0; m_ti = 1'b0; m_bd = 1'b0;
      m_irq = 1'b0; m_sw = 2'b00; m_exc = 5'd0;
    end else begin
      rise = in_at(cyc - S) & ~in_at(cyc - S - 1);
      lvl  = in_at(cyc - S - 1);
      nxt_ext    = (EDGE & m_sticky) | (~EDGE & lvl);
      nxt_sticky = EDGE & (rise | (m_sticky & ~irq_clr));
      m_irq = (|(exp_cause() >> 8 & 32'h0000_00FF & {24'h0, status_im})) & status_ie & ~status_exl;
      m_ext = nxt_ext;
      m_sticky = nxt_sticky;
      m_ti = timer_pending;
      if (mtc0_we) m_sw = mtc0_wdata[9:8];
      if (activeexception) begin
        m_exc = exccode;
        m_bd  = exc_in_delay_slot;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("cause", cause, exp_cause());
    chk("irq_req", {31'b0, irq_req}, {31'b0, m_irq});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset with everything asserted.
    tick();
    chk("rst_cause", cause, 32'h0);
    chk("rst_irq", {31'b0, irq_req}, 32'h0);
    tick();
    chk("rst_cause2", cause, 32'h0);
    reset = 1'b0; irq_in = 4'h0; timer_pending = 1'b0;
    ticks(5);

    // Level latency on line 0.
    status_im = 8'h10; status_ie = 1'b1; status_exl = 1'b0;
    irq_in = 4'b0001;
    ticks(3);
    chk("lvl_early", {31'b0, cause[12]}, 32'd0);
    tick();
    chk("lvl_k3", {31'b0, cause[12]}, 32'd1);
    chk("lvl_irq_k3", {31'b0, irq_req}, 32'd0);
    tick();
    chk("lvl_irq_k4", {31'b0, irq_req}, 32'd1);
    irq_in = 4'b0000;
    ticks(3);
    chk("lvl_hold", {31'b0, cause[12]}, 32'd1);
    tick();
    chk("lvl_drop", {31'b0, cause[12]}, 32'd0);
    tick();
    chk("lvl_irq_drop", {31'b0, irq_req}, 32'd0);

    // Edge sticky on line 1.
    irq_in = 4'b0010; tick();
    irq_in = 4'b0000; ticks(3);
    chk("edge_set", {31'b0, cause[13]}, 32'd1);
    ticks(4);
    chk("edge_stays", {31'b0, cause[13]}, 32'd1);
    irq_clr = 4'b0010; tick();
    irq_clr = 4'b0000; tick();
    chk("edge_clr", {31'b0, cause[13]}, 32'd0);
    irq_in = 4'b0010; tick();
    irq_in = 4'b0000; tick();
    irq_clr = 4'b0010; tick();
    irq_clr = 4'b0000; ticks(2);
    chk("edge_set_wins", {31'b0, cause[13]}, 32'd1);

    // Exceptions.
    activeexception = 1'b1; exccode = 5'd12; exc_in_delay_slot = 1'b1; tick();
    activeexception = 1'b0; tick();
    chk("exc12", {27'b0, cause[6:2]}, 32'd12);
    chk("bd1", {31'b0, cause[31]}, 32'd1);
    activeexception = 1'b1; exccode = 5'd8; exc_in_delay_slot = 1'b0; tick();
    activeexception = 1'b0; tick();
    chk("exc8", {27'b0, cause[6:2]}, 32'd8);
    chk("bd0", {31'b0, cause[31]}, 32'd0);

    // Software write together with an exception.
    mtc0_we = 1'b1; mtc0_wdata = 32'hFFFF_FFFF;
    activeexception = 1'b1; exccode = 5'd4; tick();
    mtc0_we = 1'b0; activeexception = 1'b0; tick();
    chk("sw_ip", {30'b0, cause[9:8]}, 32'd3);
    chk("sw_exc", {27'b0, cause[6:2]}, 32'd4);

    // Timer and masking.
    timer_pending = 1'b1; status_im = 8'h08; tick();
    chk("ti_ip3", {30'b0, cause[30], cause[11]}, 32'd3);
    tick();
    chk("ti_irq", {31'b0, irq_req}, 32'd1);
    status_exl = 1'b1; tick();
    chk("exl_mask", {31'b0, irq_req}, 32'd0);
    status_exl = 1'b0; timer_pending = 1'b0;

    // Random traffic, including occasional mid-run resets.
    for (int r = 0; r < 600; r++) begin
      reset             = ($urandom_range(0, 63) == 0);
      irq_in            = 4'($urandom_range(0, 15));
      irq_clr           = 4'($urandom_range(0, 15));
      timer_pending     = 1'($urandom_range(0, 1));
      activeexception   = ($urandom_range(0, 3) == 0);
      exccode           = 5'($urandom_range(0, 31));
      exc_in_delay_slot = 1'($urandom_range(0, 1));
      mtc0_we           = ($urandom_range(0, 3) == 0);
      mtc0_wdata        = $urandom;
      status_im         = 8'($urandom_range(0, 255));
      status_ie         = ($urandom_range(0, 3) != 0);
      status_exl        = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
